// File: rtl/pipe_pkg.sv
// pipe_pkg: shared scoreboard entry type and pipeline stage/latency constants
//   RA_MAX_W / SW_MAX : storage widths of the rd and rdy fields (cover RA_W<=8, DEPTH<=8)
//   STG_EX, STG_MEM   : stage indices after ID
//   FWD_RF            : forward select meaning "use the register-file value"
//   RDY_ALU, RDY_LOAD : usual result-ready stages for ALU ops and loads
package pipe_pkg;
   localparam int RA_MAX_W = 8;
   localparam int SW_MAX = 4;
   localparam int STG_EX = 1;
   localparam int STG_MEM = 2;
   localparam int FWD_RF = 0;
   localparam int RDY_ALU = 2;
   localparam int RDY_LOAD = 3;
   typedef struct packed {
      logic valid;
      logic we;
      logic [RA_MAX_W-1:0] rd;
      logic [SW_MAX-1:0] rdy;
   } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_match.sv
// hazard_src_match: scans the scoreboard for one ID source operand
//   rs, used : source register and whether it is actually read
//   sb       : scoreboard slots 1..DEPTH-1 (slot 1 = EX)
//   hazard   : youngest matching producer is not ready in time
//   fwd_sel  : stage to forward from, FWD_RF when none or hazard
module hazard_src_match
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int RA_W = 5,
   localparam int SW = $clog2(DEPTH + 1)
) (
   input  logic [RA_W-1:0]          rs,
   input  logic                     used,
   input  sb_entry_t [DEPTH-1:1]    sb,
   output logic                     hazard,
   output logic [SW-1:0]            fwd_sel
);
   // scanning oldest to youngest lets the youngest match overwrite older ones
   always_comb begin
      hazard = 1'b0;
      fwd_sel = SW'(FWD_RF);
      for (int s = DEPTH - 1; s >= STG_EX; s--)
         if (sb[s].valid && sb[s].we && sb[s].rd == RA_MAX_W'(rs) && rs != '0 && used) begin
            hazard = s + 1 < int'(sb[s].rdy);
            fwd_sel = hazard ? SW'(FWD_RF) : SW'(s + 1);
         end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall, flush and forwarding control for the ID stage
//   id_*          : ID instruction sources, destination and result-ready stage
//   ex_redirect   : EX instruction redirects the PC
//   stall         : hold PC and IF/ID
//   flush_if_id   : clear IF/ID
//   bubble_id_ex  : load a bubble into ID/EX
//   fwd_a, fwd_b  : registered forward selects aligned with EX
//   stall_cnt, flush_cnt : saturating event counters
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int RA_W = 5,
   parameter int CNT_W = 16,
   localparam int SW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              id_we,
   input  logic [SW-1:0]     id_rdy_stage,
   input  logic              ex_redirect,
   output logic              stall,
   output logic              flush_if_id,
   output logic              bubble_id_ex,
   output logic [SW-1:0]     fwd_a,
   output logic [SW-1:0]     fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   // the WB slot can never match (RF is write-first), so only slots 1..DEPTH-1 are kept
   sb_entry_t [DEPTH-1:1] sb_q;
   sb_entry_t ld;
   logic haz_a, haz_b;
   logic [SW-1:0] sel_a, sel_b, rdy_c;
   assign stall = id_valid & (haz_a | haz_b) & ~ex_redirect;
   assign flush_if_id = ex_redirect;
   assign bubble_id_ex = stall | ex_redirect;
   assign rdy_c = id_rdy_stage < SW'(RDY_ALU) ? SW'(RDY_ALU) :
                  id_rdy_stage > SW'(DEPTH) ? SW'(DEPTH) : id_rdy_stage;
   assign ld = (id_valid & ~bubble_id_ex) ?
               sb_entry_t'{valid: 1'b1, we: id_we, rd: RA_MAX_W'(id_rd), rdy: SW_MAX'(rdy_c)} : '0;
   hazard_src_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_a (
      .rs(id_rs1), .used(id_rs1_used), .sb(sb_q), .hazard(haz_a), .fwd_sel(sel_a));
   hazard_src_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_b (
      .rs(id_rs2), .used(id_rs2_used), .sb(sb_q), .hazard(haz_b), .fwd_sel(sel_b));
   always_ff @(posedge clk)
      if (rst) begin
         sb_q <= '0;
         fwd_a <= '0;
         fwd_b <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         sb_q[STG_EX] <= ld;
         for (int s = 2; s < DEPTH; s++) sb_q[s] <= sb_q[s-1];
         fwd_a <= bubble_id_ex ? SW'(FWD_RF) : sel_a;
         fwd_b <= bubble_id_ex ? SW'(FWD_RF) : sel_b;
         stall_cnt <= stall_cnt + CNT_W'(stall && stall_cnt != '1);
         flush_cnt <= flush_cnt + CNT_W'(ex_redirect && flush_cnt != '1);
      end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table plus scoreboard bench for DEPTH=3 and DEPTH=4/CNT_W=4 instances
module tb_pipe_hazard_ctrl;
   import pipe_pkg::*;
   typedef struct {
      logic v;
      logic [4:0] rs1, rs2;
      logic u1, u2;
      logic [4:0] rd;
      logic we;
      logic [2:0] rdy;
      logic redir;
      logic st;
      int fa, fb;
   } vec_t;
   typedef struct {
      int fa, fb, idx;
   } exp_t;
   logic clk = 0, rst = 1;
   logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_we = 0, ex_redirect = 0;
   logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
   logic [2:0] id_rdy = 0;
   logic stall3, flush3, bubble3, stall4, flush4, bubble4;
   logic [1:0] fa3, fb3;
   logic [2:0] fa4, fb4;
   logic [15:0] sc3, fc3;
   logic [3:0] sc4, fc4;
   int errs = 0, checks = 0;
   vec_t tbl[$];
   exp_t sbq[$];
   exp_t e;
   always #5 clk = ~clk;
   pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5), .CNT_W(16)) u_d3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
      .id_rdy_stage(id_rdy[1:0]), .ex_redirect(ex_redirect), .stall(stall3),
      .flush_if_id(flush3), .bubble_id_ex(bubble3), .fwd_a(fa3), .fwd_b(fb3),
      .stall_cnt(sc3), .flush_cnt(fc3));
   pipe_hazard_ctrl #(.DEPTH(4), .RA_W(5), .CNT_W(4)) u_d4 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
      .id_rdy_stage(id_rdy), .ex_redirect(ex_redirect), .stall(stall4),
      .flush_if_id(flush4), .bubble_id_ex(bubble4), .fwd_a(fa4), .fwd_b(fb4),
      .stall_cnt(sc4), .flush_cnt(fc4));
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask
   task automatic put(input vec_t t);
      id_valid = t.v;
      id_rs1 = t.rs1;
      id_rs2 = t.rs2;
      id_rs1_used = t.u1;
      id_rs2_used = t.u2;
      id_rd = t.rd;
      id_we = t.we;
      id_rdy = t.rdy;
      ex_redirect = t.redir;
   endtask
   function automatic vec_t op(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic [2:0] rdy, input logic redir);
      vec_t t;
      t = '{1'b1, r1, r2, 1'b1, 1'b1, rd, 1'b1, rdy, redir, 1'b0, 0, 0};
      return t;
   endfunction
   task automatic cyc(input vec_t t);
      @(negedge clk);
      put(t);
      #1;
   endtask
   task automatic chk_idle(input string n);
      chk({n, "_stall3"}, stall3, 0);
      chk({n, "_bubble3"}, bubble3, 0);
      chk({n, "_fwd3"}, {fa3, fb3}, 0);
      chk({n, "_cnt3"}, {sc3, fc3}, 0);
      chk({n, "_stall4"}, stall4, 0);
      chk({n, "_flush4"}, flush4, 0);
      chk({n, "_bubble4"}, bubble4, 0);
      chk({n, "_fwd4"}, {fa4, fb4}, 0);
      chk({n, "_cnt4"}, {sc4, fc4}, 0);
   endtask
   initial begin
      // v rs1 rs2 u1 u2 rd we rdy redir | stall fwd_a fwd_b (registered next cycle)
      tbl.push_back('{1, 1, 2, 1, 1, 5, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 5, 1, 1, 1, 6, 1, 2, 0, 0, 2, 0});
      tbl.push_back('{1, 3, 4, 1, 1, 7, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 7, 1, 1, 8, 1, 2, 0, 1, 0, 0});
      tbl.push_back('{1, 1, 7, 1, 1, 8, 1, 2, 0, 0, 0, 3});
      tbl.push_back('{1, 1, 2, 1, 1, 9, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 3, 4, 1, 1, 10, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 9, 12, 1, 1, 11, 1, 2, 0, 0, 3, 0});
      tbl.push_back('{1, 3, 4, 1, 1, 13, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 14, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 15, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 13, 1, 1, 16, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 0, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 1, 1, 17, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 20, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 20, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 20, 20, 1, 1, 18, 1, 2, 0, 0, 2, 2});
      tbl.push_back('{1, 1, 2, 1, 1, 21, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 21, 1, 0, 1, 19, 1, 2, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 22, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{1, 22, 1, 1, 1, 23, 1, 2, 1, 0, 0, 0});
      tbl.push_back('{1, 22, 1, 1, 1, 23, 1, 2, 0, 0, 3, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 24, 1, 3, 0, 0, 0, 0});
      tbl.push_back('{0, 24, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 2, 1, 1, 25, 1, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 25, 24, 1, 1, 26, 1, 2, 0, 0, 2, 0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      rst = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i]);
         chk($sformatf("v%0d_stall", i), stall3, tbl[i].st);
         chk($sformatf("v%0d_flush", i), flush3, tbl[i].redir);
         chk($sformatf("v%0d_bubble", i), bubble3, tbl[i].st | tbl[i].redir);
         sbq.push_back('{tbl[i].fa, tbl[i].fb, i});
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         chk($sformatf("v%0d_fwd_a", e.idx), fa3, e.fa);
         chk($sformatf("v%0d_fwd_b", e.idx), fb3, e.fb);
      end
      chk("d3_stall_cnt", sc3, 1);
      chk("d3_flush_cnt", fc3, 1);
      @(negedge clk);
      put('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      rst = 1;
      @(negedge clk);
      rst = 0;
      cyc(op(1, 2, 5, 4, 0));
      chk("a_prod_stall", stall4, 0);
      cyc(op(5, 2, 6, RDY_ALU, 0));
      chk("a_stall1", stall4, 1);
      chk("a_bubble1", bubble4, 1);
      cyc(op(5, 2, 6, RDY_ALU, 0));
      chk("a_stall2", stall4, 1);
      cyc(op(5, 2, 6, RDY_ALU, 0));
      chk("a_stall3", stall4, 0);
      @(posedge clk);
      #1;
      chk("a_fwd_a", fa4, 4);
      cyc(op(1, 2, 7, 4, 0));
      chk("b_prod_stall", stall4, 0);
      cyc(op(7, 2, 9, RDY_ALU, 0));
      chk("b_stall1", stall4, 1);
      cyc(op(7, 2, 9, RDY_ALU, 1));
      chk("b_redir_stall", stall4, 0);
      chk("b_redir_flush", flush4, 1);
      chk("b_redir_bubble", bubble4, 1);
      @(posedge clk);
      #1;
      chk("b_fwd_a", fa4, 0);
      chk("b_flush_cnt", fc4, 1);
      chk("b_stall_cnt", sc4, 3);
      for (int i = 0; i < 12; i++) begin
         cyc(op(1, 2, 8, 7, 0));
         chk($sformatf("sat%0d_prod", i), stall4, 0);
         for (int k = 0; k < 3; k++) begin
            cyc(op(8, 2, 10, RDY_ALU, 0));
            chk($sformatf("sat%0d_stall%0d", i, k), stall4, k < 2 ? 1 : 0);
         end
      end
      @(posedge clk);
      #1;
      chk("sat_stall_cnt", sc4, 15);
      for (int i = 0; i < 21; i++) cyc(op(1, 2, 11, RDY_ALU, 1));
      @(posedge clk);
      #1;
      chk("sat_flush_cnt", fc4, 15);
      chk("sat_stall_hold", sc4, 15);
      cyc(op(1, 2, 9, RDY_LOAD + 1, 0));
      cyc(op(9, 9, 12, RDY_ALU, 0));
      rst = 1;
      chk("mr_pre_stall", stall4, 1);
      @(negedge clk);
      rst = 0;
      #1;
      chk_idle("midrst");
      @(posedge clk);
      #1;
      chk("mr_fwd_a4", fa4, 0);
      chk("mr_fwd_b4", fb4, 0);
      chk("mr_fwd_a3", fa3, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. It replaces the fixed load-use stall, the EX-branch stall and the two-source forwarding selectors.
- Tracks every in-flight register write in a scoreboard shift register, one slot per post-ID stage.
- Decides per cycle whether the ID instruction stalls, whether the front end flushes, and which stage EX operands forward from.
- Adds behaviour the current pipeline lacks: variable result latency per instruction, flush-on-redirect instead of branch stall, and saturating stall/flush counters.

Parameters:
- DEPTH, 3, number of stages after ID (1=EX, 2=MEM, ..., DEPTH=WB); legal range 2..8
- RA_W, 5, register address width
- CNT_W, 16, width of performance counters
- SW, $clog2(DEPTH+1), width of stage-index fields (derived, not overridable)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RA_W  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RA_W  ID destination register
- id_we  in  1  ID instruction writes RF
- id_rdy_stage  in  SW  first stage whose pipeline-register output holds the result (ALU=2, load=3, multi-cycle op higher)
- ex_redirect  in  1  EX-stage instruction redirects PC (taken branch/jump)
- stall  out  1  hold PC and IF/ID (combinational)
- flush_if_id  out  1  clear IF/ID (combinational, = ex_redirect)
- bubble_id_ex  out  1  load bubble into ID/EX (combinational, = stall | ex_redirect)
- fwd_a, fwd_b  out  SW  registered, aligned with EX: 0 = RF value, k = forward from stage-k pipeline register output
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Scoreboard: DEPTH slots {valid, we, rd, rdy}; slot s describes the instruction in stage s.
- Each cycle every slot shifts s -> s+1; slot DEPTH drops out. No back-pressure downstream of ID.
- Slot 1 load: if id_valid & !stall & !ex_redirect, load {1, id_we, id_rd, clamp(id_rdy_stage)}; otherwise load all zeros (bubble).
- Clamp: rdy < 2 -> 2; rdy > DEPTH -> DEPTH.
- Match for a source rs, slot s in 1..DEPTH-1: valid & we & rd==rs & rs!=0 & rs_used. Slot DEPTH never matches; RF is write-first, so ID reads the WB value directly.
- Youngest matching slot (smallest s) has priority.
- Source hazard: youngest match exists and s+1 < rdy.
- stall = id_valid & (hazard_rs1 | hazard_rs2) & !ex_redirect. Redirect wins over stall in the same cycle.
- Forward select, computed in ID: youngest match with s+1 >= rdy gives s+1; no match gives 0.
- fwd_a/fwd_b register on every clk edge. They are loaded with 0 when bubble_id_ex is asserted, so a bubble never forwards.
- ex_redirect: the slot-1 instruction (the branch itself) is kept; the ID instruction is discarded (bubble) and IF/ID is cleared.
- Stall latency: a consumer stalls exactly max(0, rdy - s - 1) cycles. The scoreboard advances during a stall, so the hazard self-clears.
- Counters: stall_cnt += 1 on every cycle stall=1; flush_cnt += 1 on every cycle ex_redirect=1. Both hold at 2^CNT_W-1.
- Reset: all slots invalid; fwd_a = fwd_b = 0; counters = 0. stall, flush_if_id and bubble_id_ex follow their equations, so they are 0 once ex_redirect is 0.
- Reset mid-operation discards all in-flight entries; the first post-reset instruction sees no hazards.

Decomposition:
- Shared package pipe_pkg holds:
  - scoreboard entry struct {valid, we, rd, rdy}
  - stage constants STG_EX=1, STG_MEM=2
  - FWD_RF=0
  - result-latency constants RDY_ALU=2, RDY_LOAD=3
- One natural sub-module: hazard_src_match, instantiated once per source. It takes (rs, used, scoreboard) and returns (hazard, fwd_sel).

Test Plan (DEPTH=3 unless stated):
- add x5 (rdy=2), next cycle add x6,x5,x1 (rs1=5) -> stall=0; fwd_a=2 in EX cycle; stall_cnt stays 0.
- lw x5 (rdy=3), next cycle use x5 as rs2 -> stall=1 for exactly 1 cycle, bubble_id_ex=1; then fwd_b=3; stall_cnt=1.
- lw x5, unrelated instr, then use x5 -> no stall; fwd=3. Repeat at distance 3 -> fwd=0 (RF write-first path).
- add x0 (we=1, rd=0), then use x0 -> no stall; fwd=0.
- DEPTH=4, op rdy=4, immediately consumed -> stall 2 cycles then fwd=4. Raise ex_redirect on the 2nd stall cycle -> stall=0, flush_if_id=1, bubble_id_ex=1, flush_cnt=1, fwd=0.
- Hold stall/redirect conditions 2^CNT_W+5 cycles with CNT_W=4 -> counter saturates at 15. Assert rst mid-stream -> all outputs 0 next cycle; no stale forwarding.
